// File: rtl/holy_axil_master_if.sv
// AXI-Lite bus bundle (AW, W, B, AR, R channels) shared by manager and subordinate.
// Ports: master modport drives addresses, data and valids; slave modport drives readies and responses.
interface axi_lite_if;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );
endinterface

// File: rtl/holy_axil_master.sv
// AXI-Lite initiator: one outstanding single-beat load/store, with per-state timeout abort.
// Ports: clk/rst (async high); req_* core request (ready only in IDLE); rsp_* one-cycle
// completion pulse with data/error; m_axi_lite manager port (AW, W, B, AR, R).
module holy_axil_master #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    axi_lite_if.master  m_axi_lite
);

    typedef enum logic [2:0] {
        IDLE,
        WR_AW_W,
        WR_B,
        RD_AR,
        RD_R
    } state_t;

    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [31:0] cnt_q, cnt_d;

    logic aw_fire;
    logic w_fire;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0;
        cnt_d       = cnt_q;
        aw_fire     = awvalid_q && m_axi_lite.awready;
        w_fire      = wvalid_q && m_axi_lite.wready;

        unique case (state_q)
            IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (req_valid) begin
                    if (req_addr[1:0] != 2'b00) begin
                        // Misaligned: answer locally, the bus never sees it.
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (req_we) begin
                        addr_d    = req_addr;
                        wdata_d   = req_wdata;
                        wstrb_d   = req_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_AW_W;
                    end else begin
                        addr_d    = req_addr;
                        arvalid_d = 1'b1;
                        state_d   = RD_AR;
                    end
                end
            end
            WR_AW_W: begin
                // AW and W complete independently, in either order.
                aw_done_d = aw_done_q | aw_fire;
                w_done_d  = w_done_q | w_fire;
                if (aw_fire) awvalid_d = 1'b0;
                if (w_fire)  wvalid_d  = 1'b0;
                if (aw_done_d && w_done_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_B;
                end
            end
            WR_B: begin
                if (m_axi_lite.bvalid) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = (m_axi_lite.bresp != 2'b00);
                    state_d     = IDLE;
                end
            end
            RD_AR: begin
                if (m_axi_lite.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_R;
                end
            end
            RD_R: begin
                if (m_axi_lite.rvalid) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = (m_axi_lite.rresp != 2'b00);
                    rsp_rdata_d = m_axi_lite.rdata;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A stuck state is abandoned; progress in the final counted cycle wins.
        if (TO_EN && state_q != IDLE && state_d == state_q && cnt_q == TO_LAST) begin
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            bready_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'hFFFF_FFFF;
            state_d     = IDLE;
        end

        // Counter restarts on every state entry.
        if (state_q == IDLE || state_d != state_q) cnt_d = 32'h0;
        else cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            wstrb_q     <= 4'h0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            cnt_q       <= 32'h0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            cnt_q       <= cnt_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

    assign m_axi_lite.awaddr  = addr_q;
    assign m_axi_lite.awprot  = 3'b000;
    assign m_axi_lite.awvalid = awvalid_q;
    assign m_axi_lite.wdata   = wdata_q;
    assign m_axi_lite.wstrb   = wstrb_q;
    assign m_axi_lite.wvalid  = wvalid_q;
    assign m_axi_lite.bready  = bready_q;
    assign m_axi_lite.araddr  = addr_q;
    assign m_axi_lite.arprot  = 3'b000;
    assign m_axi_lite.arvalid = arvalid_q;
    assign m_axi_lite.rready  = rready_q;

endmodule

// File: tb/tb_holy_axil_master.sv
// Bench for holy_axil_master: directed plus random transactions against a
// wait-state slave, with an expected-result model derived from per-phase delays.
module tb_holy_axil_master;
    localparam int TO = 8;
    localparam int NEVER = 99;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [3:0]  req_wstrb = 4'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    axi_lite_if axi ();

    holy_axil_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .m_axi_lite (axi)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Slave behaviour: each ready/valid appears after a configured number of waiting cycles.
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  resp_c = 2'b00;
    logic [31:0] rdata_c = 32'h0;

    initial begin
        int aw_wt, w_wt, b_wt, ar_wt, r_wt;
        aw_wt = 0; w_wt = 0; b_wt = 0; ar_wt = 0; r_wt = 0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
        axi.arready = 1'b0; axi.rvalid = 1'b0;
        axi.bresp = 2'b00; axi.rresp = 2'b00; axi.rdata = 32'h0;
        forever begin
            @(negedge clk);
            aw_wt = axi.awvalid ? aw_wt + 1 : 0;
            w_wt  = axi.wvalid  ? w_wt + 1  : 0;
            b_wt  = axi.bready  ? b_wt + 1  : 0;
            ar_wt = axi.arvalid ? ar_wt + 1 : 0;
            r_wt  = axi.rready  ? r_wt + 1  : 0;
            axi.awready = axi.awvalid && (aw_wt > aw_dly);
            axi.wready  = axi.wvalid  && (w_wt > w_dly);
            axi.bvalid  = axi.bready  && (b_wt > b_dly);
            axi.arready = axi.arvalid && (ar_wt > ar_dly);
            axi.rvalid  = axi.rready  && (r_wt > r_dly);
            axi.bresp   = resp_c;
            axi.rresp   = resp_c;
            axi.rdata   = rdata_c;
        end
    end

    // Bus monitor: per-channel valid/ready cycle counts, handshakes, payload mismatches.
    logic [31:0] e_addr = 32'h0, e_wdata = 32'h0;
    logic [3:0]  e_wstrb = 4'h0;
    int m_awv = 0, m_aw = 0, m_wv = 0, m_w = 0, m_bv = 0, m_b = 0;
    int m_arv = 0, m_ar = 0, m_rv = 0, m_r = 0, m_bad = 0;

    always @(posedge clk) begin
        if (axi.awvalid) begin
            m_awv++;
            if (axi.awready) m_aw++;
            if (axi.awaddr !== e_addr || axi.awprot !== 3'b0) m_bad++;
        end
        if (axi.wvalid) begin
            m_wv++;
            if (axi.wready) m_w++;
            if (axi.wdata !== e_wdata || axi.wstrb !== e_wstrb) m_bad++;
        end
        if (axi.bready) begin
            m_bv++;
            if (axi.bvalid) m_b++;
        end
        if (axi.arvalid) begin
            m_arv++;
            if (axi.arready) m_ar++;
            if (axi.araddr !== e_addr || axi.arprot !== 3'b0) m_bad++;
        end
        if (axi.rready) begin
            m_rv++;
            if (axi.rvalid) m_r++;
        end
    end

    function automatic int ph_cyc(input int d);
        return (d + 1 > TO) ? TO : d + 1;
    endfunction

    function automatic int ph_hs(input int d);
        return (d + 1 > TO) ? 0 : 1;
    endfunction

    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] ws,
                       input int awd, input int wdd, input int bd,
                       input int ard, input int rd,
                       input logic [1:0] resp, input logic [31:0] rdat);
        int x_lat, x_awv, x_aw, x_wv, x_w, x_bv, x_b, x_arv, x_ar, x_rv, x_r;
        logic x_err;
        logic [31:0] x_rdata;
        int s_awv, s_aw, s_wv, s_w, s_bv, s_b, s_arv, s_ar, s_rv, s_r, s_bad;
        int n, p1, p2;

        aw_dly = awd; w_dly = wdd; b_dly = bd; ar_dly = ard; r_dly = rd;
        resp_c = resp; rdata_c = rdat;
        e_addr = addr; e_wdata = wd; e_wstrb = ws;

        x_awv = 0; x_aw = 0; x_wv = 0; x_w = 0; x_bv = 0; x_b = 0;
        x_arv = 0; x_ar = 0; x_rv = 0; x_r = 0;
        if (addr[1:0] != 2'b00) begin
            x_lat = 1; x_err = 1'b1; x_rdata = 32'h0;
        end else begin
            p1 = (we ? ((awd > wdd) ? awd : wdd) : ard) + 1;
            p2 = (we ? bd : rd) + 1;
            if (we) begin
                x_awv = ph_cyc(awd); x_aw = ph_hs(awd);
                x_wv = ph_cyc(wdd);  x_w = ph_hs(wdd);
            end else begin
                x_arv = ph_cyc(ard); x_ar = ph_hs(ard);
            end
            if (p1 > TO) begin
                x_lat = TO + 1; x_err = 1'b1; x_rdata = 32'hFFFF_FFFF;
            end else begin
                if (we) begin x_bv = ph_cyc(bd); x_b = ph_hs(bd); end
                else begin x_rv = ph_cyc(rd); x_r = ph_hs(rd); end
                if (p2 > TO) begin
                    x_lat = p1 + TO + 1; x_err = 1'b1; x_rdata = 32'hFFFF_FFFF;
                end else begin
                    x_lat = p1 + p2 + 1;
                    x_err = (resp != 2'b00);
                    x_rdata = we ? 32'h0 : rdat;
                end
            end
        end

        s_awv = m_awv; s_aw = m_aw; s_wv = m_wv; s_w = m_w; s_bv = m_bv; s_b = m_b;
        s_arv = m_arv; s_ar = m_ar; s_rv = m_rv; s_r = m_r; s_bad = m_bad;

        @(negedge clk);
        chk({tag, ".ready"}, req_ready, 1);
        req_valid = 1'b1; req_we = we; req_addr = addr;
        req_wdata = wd; req_wstrb = ws;
        n = 0;
        do begin
            @(negedge clk);
            req_valid = 1'b0;
            n++;
        end while (!rsp_valid && n < 40);

        chk({tag, ".lat"}, n, x_lat);
        chk({tag, ".err"}, rsp_err, x_err);
        chk({tag, ".rdata"}, rsp_rdata, x_rdata);
        chk({tag, ".awv"}, m_awv - s_awv, x_awv);
        chk({tag, ".aw"}, m_aw - s_aw, x_aw);
        chk({tag, ".wv"}, m_wv - s_wv, x_wv);
        chk({tag, ".w"}, m_w - s_w, x_w);
        chk({tag, ".bready"}, m_bv - s_bv, x_bv);
        chk({tag, ".b"}, m_b - s_b, x_b);
        chk({tag, ".arv"}, m_arv - s_arv, x_arv);
        chk({tag, ".ar"}, m_ar - s_ar, x_ar);
        chk({tag, ".rready"}, m_rv - s_rv, x_rv);
        chk({tag, ".r"}, m_r - s_r, x_r);
        chk({tag, ".payload"}, m_bad - s_bad, 0);
        @(negedge clk);
        chk({tag, ".pulse_end"}, {rsp_valid, req_ready}, 2'b01);
    endtask

    initial begin
        int pulses;
        logic we;
        logic [31:0] addr;
        logic [1:0] resp;

        #1 rst = 1'b1;
        #1;
        chk("reset.req_ready", req_ready, 1);
        chk("reset.rsp", {rsp_valid, rsp_err}, 0);
        chk("reset.rsp_rdata", rsp_rdata, 0);
        chk("reset.valids", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 0);
        chk("reset.addr", axi.awaddr | axi.araddr | axi.wdata, 0);
        @(negedge clk);
        rst = 1'b0;

        txn("wr_zero_wait", 1, 32'h4000_0000, 32'h0000_001F, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0);
        txn("rd_ar_wait3", 0, 32'h4000_0004, 0, 0, 0, 0, 0, 3, 0, 2'b00, 32'h0000_0003);
        txn("wr_w_first", 1, 32'h4000_0008, 32'hA5A5_5A5A, 4'h3, 4, 2, 1, 0, 0, 2'b00, 0);
        txn("wr_aw_first", 1, 32'h4000_000C, 32'h1234_5678, 4'hC, 1, 3, 0, 0, 0, 2'b10, 0);
        txn("rd_decerr", 0, 32'h4000_0010, 0, 0, 0, 0, 0, 0, 2, 2'b11, 32'hFFFF_FFFF);
        txn("rd_misalign", 0, 32'h4000_0002, 0, 0, 0, 0, 0, 0, 0, 2'b00, 32'h55);
        txn("wr_misalign", 1, 32'h4000_0003, 32'h77, 4'h1, 0, 0, 0, 0, 0, 2'b00, 0);
        txn("wr_b_timeout", 1, 32'h4000_0020, 32'hDEAD_BEEF, 4'hF, 0, 0, NEVER, 0, 0, 2'b00, 0);
        txn("wr_aw_timeout", 1, 32'h4000_0024, 32'h0BAD_F00D, 4'hF, NEVER, 2, 0, 0, 0, 2'b00, 0);
        txn("rd_ar_timeout", 0, 32'h4000_0028, 0, 0, 0, 0, 0, NEVER, 0, 2'b00, 0);
        txn("rd_edge7", 0, 32'h4000_002C, 0, 0, 0, 0, 0, 7, 7, 2'b00, 32'hCAFE_0007);

        // Reset while waiting for R: everything clears at once and no response appears.
        ar_dly = 0; r_dly = NEVER; e_addr = 32'h4000_0030;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h4000_0030;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 10 && !axi.rready; k++) @(negedge clk);
        chk("rst_mid.in_rd_r", axi.rready, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid.outs", {axi.rready, axi.arvalid, rsp_valid, req_ready}, 4'b0001);
        chk("rst_mid.araddr", axi.araddr, 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        chk("rst_mid.no_rsp", pulses, 0);
        txn("rd_after_rst", 0, 32'h4000_0034, 0, 0, 0, 0, 0, 1, 1, 2'b00, 32'h0000_BEEF);

        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1));
            addr = $urandom;
            addr[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            txn("rnd", we, addr, $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5),
                $urandom_range(0, 5), $urandom_range(0, 5), resp, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
